// File: rtl/hdmi_timing_gen.sv
// hdmi_timing_gen
// ---------------------------------------------------------------------------
// Video timing generator and pixel-fetch sequencer for the ADV7513 HDMI path.
// Produces DE/HSYNC/VSYNC/FRAME_START for a parametrised raster, drives the
// address of an external pixel ROM, compensates the ROM read latency
// (PIPE_DEPTH) and supports 2^SCALE_SHIFT pixel/line replication.
//
// Ports:
//   CLK_PX       in   1           pixel clock (only clock)
//   RST_n        in   1           synchronous active-low reset
//   EN           in   1           timing enable; low forces a clean restart
//   PX_IN        in   24          ROM pixel data {R,G,B}, PIPE_DEPTH after PX_ADDR
//   PATTERN      in   1           colour-bar select (only with the macro below)
//   PX_ADDR      out  ADDR_WIDTH  registered pixel ROM address
//   DE           out  1           data enable
//   HSYNC        out  1           horizontal sync (level set by HS_POL)
//   VSYNC        out  1           vertical sync (level set by VS_POL)
//   HDMI_PX      out  24          registered output pixel
//   FRAME_START  out  1           pulse with the first DE of each frame
//
// Optional feature macro: HDMI_TIMING_GEN_PATTERN_EN
//   When defined, adds PATTERN and an 8-bar colour test pattern on HDMI_PX.
// ---------------------------------------------------------------------------
module hdmi_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int CTR_WIDTH   = 12,
  parameter int ADDR_WIDTH  = 19,
  parameter int PIPE_DEPTH  = 2,
  parameter int SCALE_SHIFT = 0
) (
  input  logic                  CLK_PX,
  input  logic                  RST_n,
  input  logic                  EN,
  input  logic [23:0]           PX_IN,
`ifdef HDMI_TIMING_GEN_PATTERN_EN
  input  logic                  PATTERN,
`endif
  output logic [ADDR_WIDTH-1:0] PX_ADDR,
  output logic                  DE,
  output logic                  HSYNC,
  output logic                  VSYNC,
  output logic [23:0]           HDMI_PX,
  output logic                  FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Stages between the counter state and the output registers.
  localparam int NS = PIPE_DEPTH + 1;

  localparam logic [CTR_WIDTH-1:0] H_ACT_C    = CTR_WIDTH'(H_ACTIVE);
  localparam logic [CTR_WIDTH-1:0] H_LAST_ACT = CTR_WIDTH'(H_ACTIVE - 1);
  localparam logic [CTR_WIDTH-1:0] HS_START   = CTR_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CTR_WIDTH-1:0] HS_END     = CTR_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CTR_WIDTH-1:0] H_LAST     = CTR_WIDTH'(H_TOTAL - 1);
  localparam logic [CTR_WIDTH-1:0] V_ACT_C    = CTR_WIDTH'(V_ACTIVE);
  localparam logic [CTR_WIDTH-1:0] VS_START   = CTR_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CTR_WIDTH-1:0] VS_END     = CTR_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CTR_WIDTH-1:0] V_LAST     = CTR_WIDTH'(V_TOTAL - 1);
  // Low SCALE_SHIFT bits of a counter; empty mask (scale 1) always matches.
  localparam logic [CTR_WIDTH-1:0] REP_MASK   = CTR_WIDTH'((1 << SCALE_SHIFT) - 1);

  logic [CTR_WIDTH-1:0]  h;
  logic [CTR_WIDTH-1:0]  v;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] line_base;

  logic active;
  logic hs_asrt;
  logic vs_asrt;
  logic frame_first;
  logic h_rep_end;
  logic v_rep_end;
  logic [23:0] px_sel;

  logic [NS-1:0] act_pipe;
  logic [NS-1:0] hs_pipe;
  logic [NS-1:0] vs_pipe;
  logic [NS-1:0] fs_pipe;

`ifdef HDMI_TIMING_GEN_PATTERN_EN
  logic [NS-1:0]        pat_pipe;
  logic [CTR_WIDTH-1:0] h_pipe [NS];

  // Bar index from fixed bar edges i*H_ACTIVE/8; loop folds to constants.
  function automatic logic [23:0] bar_color(input logic [CTR_WIDTH-1:0] hp);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (hp >= CTR_WIDTH'((i * H_ACTIVE) / 8)) idx = 3'(i);
    end
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  endfunction
`endif

  // Stage-0 decode of the raster position.
  always_comb begin
    active      = (h < H_ACT_C) && (v < V_ACT_C);
    hs_asrt     = (h >= HS_START) && (h < HS_END);
    vs_asrt     = (v >= VS_START) && (v < VS_END);
    frame_first = (h == {CTR_WIDTH{1'b0}}) && (v == {CTR_WIDTH{1'b0}});
    h_rep_end   = (h & REP_MASK) == REP_MASK;
    v_rep_end   = (v & REP_MASK) == REP_MASK;
  end

  // Raster counters and replicated ROM address sequencing.
  always_ff @(posedge CLK_PX) begin
    if (!RST_n || !EN) begin
      h         <= {CTR_WIDTH{1'b0}};
      v         <= {CTR_WIDTH{1'b0}};
      addr      <= {ADDR_WIDTH{1'b0}};
      line_base <= {ADDR_WIDTH{1'b0}};
      PX_ADDR   <= {ADDR_WIDTH{1'b0}};
    end else begin
      PX_ADDR <= addr;
      if (h == H_LAST) begin
        h <= {CTR_WIDTH{1'b0}};
        v <= (v == V_LAST) ? {CTR_WIDTH{1'b0}} : v + CTR_WIDTH'(1);
      end else begin
        h <= h + CTR_WIDTH'(1);
      end
      if ((h == H_LAST) && (v == V_LAST)) begin
        addr      <= {ADDR_WIDTH{1'b0}};
        line_base <= {ADDR_WIDTH{1'b0}};
      end else if (active && (h == H_LAST_ACT)) begin
        // Last replica of a source line moves on; others rewind to its start.
        if (v_rep_end) begin
          addr      <= addr + ADDR_WIDTH'(1);
          line_base <= addr + ADDR_WIDTH'(1);
        end else begin
          addr <= line_base;
        end
      end else if (active && h_rep_end) begin
        addr <= addr + ADDR_WIDTH'(1);
      end else begin
        addr <= addr;
      end
    end
  end

`ifdef HDMI_TIMING_GEN_PATTERN_EN
  // Pattern select and column carried alongside the timing pipeline.
  always_ff @(posedge CLK_PX) begin
    if (!RST_n || !EN) begin
      pat_pipe <= {NS{1'b0}};
      for (int i = 0; i < NS; i++) h_pipe[i] <= {CTR_WIDTH{1'b0}};
    end else begin
      pat_pipe  <= {pat_pipe[NS-2:0], PATTERN};
      h_pipe[0] <= h;
      for (int i = 1; i < NS; i++) h_pipe[i] <= h_pipe[i-1];
    end
  end

  // Output pixel source: colour bars or ROM data.
  always_comb begin
    if (pat_pipe[NS-1]) begin
      px_sel = bar_color(h_pipe[NS-1]);
    end else begin
      px_sel = PX_IN;
    end
  end
`else
  // Output pixel source: ROM data only.
  always_comb begin
    px_sel = PX_IN;
  end
`endif

  // Timing pipeline delaying stage-0 flags to align with HDMI_PX.
  always_ff @(posedge CLK_PX) begin
    if (!RST_n || !EN) begin
      act_pipe    <= {NS{1'b0}};
      hs_pipe     <= {NS{1'b0}};
      vs_pipe     <= {NS{1'b0}};
      fs_pipe     <= {NS{1'b0}};
      DE          <= 1'b0;
      FRAME_START <= 1'b0;
      HSYNC       <= ~HS_POL;
      VSYNC       <= ~VS_POL;
      HDMI_PX     <= 24'h000000;
    end else begin
      act_pipe    <= {act_pipe[NS-2:0], active};
      hs_pipe     <= {hs_pipe[NS-2:0], hs_asrt};
      vs_pipe     <= {vs_pipe[NS-2:0], vs_asrt};
      fs_pipe     <= {fs_pipe[NS-2:0], frame_first};
      DE          <= act_pipe[NS-1];
      FRAME_START <= fs_pipe[NS-1];
      HSYNC       <= hs_pipe[NS-1] ? HS_POL : ~HS_POL;
      VSYNC       <= vs_pipe[NS-1] ? VS_POL : ~VS_POL;
      // PX_IN here belongs to the pixel leaving the last stage.
      HDMI_PX     <= act_pipe[NS-1] ? px_sel : 24'h000000;
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// tb_hdmi_timing_gen
// Bench for hdmi_timing_gen on a 14x8 raster (8 active x 4 active lines).
// Three instances share clock/reset/enable: base, SCALE_SHIFT=1, and
// inverted sync polarity. Each has a 2-cycle ROM model returning its address.
module tb_hdmi_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pattern = 1'b0;

  logic [18:0] addr0, addr1, addr2;
  logic [18:0] r1_0, r2_0, r1_1, r2_1, r1_2, r2_2;
  logic de0, hs0, vs0, fs0, de1, hs1, vs1, fs1, de2, hs2, vs2, fs2;
  logic [23:0] px0, px1, px2;

  typedef struct packed {
    logic        de;
    logic        fs;
    logic        hs0;
    logic        vs0;
    logic        hs2;
    logic        vs2;
    logic [23:0] px0;
    logic [23:0] px1;
    logic [18:0] addr;
  } exp_t;

  exp_t q[$];
  int   k = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // ROM models: data for an address appears two cycles after PX_ADDR.
  always_ff @(posedge clk) begin
    r1_0 <= addr0; r2_0 <= r1_0;
    r1_1 <= addr1; r2_1 <= r1_1;
    r1_2 <= addr2; r2_2 <= r1_2;
  end

  hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .PIPE_DEPTH(2), .SCALE_SHIFT(0)) dut0 (
    .CLK_PX(clk), .RST_n(rst_n), .EN(en), .PX_IN({5'b0, r2_0}),
`ifdef HDMI_TIMING_GEN_PATTERN_EN
    .PATTERN(pattern),
`endif
    .PX_ADDR(addr0), .DE(de0), .HSYNC(hs0), .VSYNC(vs0),
    .HDMI_PX(px0), .FRAME_START(fs0));

  hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .PIPE_DEPTH(2), .SCALE_SHIFT(1)) dut1 (
    .CLK_PX(clk), .RST_n(rst_n), .EN(en), .PX_IN({5'b0, r2_1}),
`ifdef HDMI_TIMING_GEN_PATTERN_EN
    .PATTERN(1'b0),
`endif
    .PX_ADDR(addr1), .DE(de1), .HSYNC(hs1), .VSYNC(vs1),
    .HDMI_PX(px1), .FRAME_START(fs1));

  hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .HS_POL(1'b1), .VS_POL(1'b1),
                    .PIPE_DEPTH(2), .SCALE_SHIFT(0)) dut2 (
    .CLK_PX(clk), .RST_n(rst_n), .EN(en), .PX_IN({5'b0, r2_2}),
`ifdef HDMI_TIMING_GEN_PATTERN_EN
    .PATTERN(1'b0),
`endif
    .PX_ADDR(addr2), .DE(de2), .HSYNC(hs2), .VSYNC(vs2),
    .HDMI_PX(px2), .FRAME_START(fs2));

  function automatic logic [23:0] bar(input int i);
    case (i)
      0:       bar = 24'hFFFFFF;
      1:       bar = 24'hFFFF00;
      2:       bar = 24'h00FFFF;
      3:       bar = 24'h00FF00;
      4:       bar = 24'hFF00FF;
      5:       bar = 24'hFF0000;
      6:       bar = 24'h0000FF;
      default: bar = 24'h000000;
    endcase
  endfunction

  // Outputs for raster position n (n-th counter state since enable).
  function automatic exp_t model(input int n, input bit pat);
    exp_t m;
    int pos, h, v;
    bit act, hsa, vsa;
    pos = n % 112; h = pos % 14; v = pos / 14;
    act = (h < 8) && (v < 4);
    hsa = (h >= 10) && (h < 13);
    vsa = (v >= 5) && (v < 7);
    m.de = act; m.fs = (pos == 0);
    m.hs0 = !hsa; m.vs0 = !vsa; m.hs2 = hsa; m.vs2 = vsa;
    m.px0 = act ? (pat ? bar(h) : 24'(v * 8 + h)) : 24'h000000;
    m.px1 = act ? 24'((v / 2) * 4 + h / 2) : 24'h000000;
    m.addr = 19'h0;
    return m;
  endfunction

  // Internal address of the base instance at raster position pos.
  function automatic logic [18:0] addr_at(input int pos);
    int h, v;
    h = pos % 14; v = pos / 14;
    if (v >= 4) return 19'd32;
    if (h < 8) return 19'(v * 8 + h);
    return 19'((v + 1) * 8);
  endfunction

  // Advance one clock: scoreboard push at the edge, pop for this cycle.
  task automatic tick(output exp_t e);
    @(posedge clk);
    if (!rst_n || !en) begin
      q.delete();
      k = 0;
    end else begin
      q.push_back(model(k, pattern));
      k++;
    end
    @(negedge clk);
    if (k >= 4 && q.size() > 0) e = q.pop_front();
    else e = '{de: 1'b0, fs: 1'b0, hs0: 1'b1, vs0: 1'b1, hs2: 1'b0, vs2: 1'b0,
               px0: 24'h0, px1: 24'h0, addr: 19'h0};
    e.addr = (k == 0) ? 19'h0 : addr_at((k - 1) % 112);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(e);
      tests++;
      if ({de0, fs0, hs0, vs0, px0, addr0, de2, hs2, vs2} !==
          {1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 19'h0, 1'b0, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL reset: de=%b fs=%b hs=%b vs=%b px=%h addr=%h hs2=%b vs2=%b required idle",
                 de0, fs0, hs0, vs0, px0, addr0, hs2, vs2);
      end
    end
    rst_n = 1'b1;
    tick(e);
  endtask

  task automatic test_timing();
    exp_t e;
    en = 1'b1;
    for (int i = 0; i < 228; i++) begin
      tick(e);
      tests++;
      if ({de0, fs0, hs0, vs0} !== {e.de, e.fs, e.hs0, e.vs0}) begin
        fails++;
        $display("FAIL timing k=%0d: de/fs/hs/vs=%b%b%b%b required %b%b%b%b",
                 k, de0, fs0, hs0, vs0, e.de, e.fs, e.hs0, e.vs0);
      end
    end
  endtask

  task automatic test_data();
    exp_t e;
    for (int i = 0; i < 112; i++) begin
      tick(e);
      tests++;
      if ({px0, addr0} !== {e.px0, e.addr}) begin
        fails++;
        $display("FAIL data k=%0d: px=%h addr=%0d required px=%h addr=%0d",
                 k, px0, addr0, e.px0, e.addr);
      end
    end
  endtask

  task automatic test_scale();
    exp_t e;
    for (int i = 0; i < 224; i++) begin
      tick(e);
      tests++;
      if ({de1, px1} !== {e.de, e.px1}) begin
        fails++;
        $display("FAIL scale k=%0d: de=%b px=%h required de=%b px=%h",
                 k, de1, px1, e.de, e.px1);
      end
    end
  endtask

  task automatic test_en_drop();
    exp_t e;
    int guard;
    guard = 0;
    while ((k % 112) != 33 && guard < 200) begin
      tick(e);
      guard++;
    end
    tests++;
    if ((k % 112) != 33) begin
      fails++;
      $display("FAIL en_drop_search: position %0d required 33", k % 112);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(e);
      tests++;
      if ({de0, hs0, vs0, px0, fs0} !== {1'b0, 1'b1, 1'b1, 24'h0, 1'b0}) begin
        fails++;
        $display("FAIL en_low: de=%b hs=%b vs=%b px=%h fs=%b required 0 1 1 0 0",
                 de0, hs0, vs0, px0, fs0);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(e);
      tests++;
      if ({de0, fs0, hs0, vs0, px0} !== {e.de, e.fs, e.hs0, e.vs0, e.px0}) begin
        fails++;
        $display("FAIL en_restart k=%0d: de=%b fs=%b px=%h required de=%b fs=%b px=%h",
                 k, de0, fs0, px0, e.de, e.fs, e.px0);
      end
    end
  endtask

  task automatic test_polarity();
    exp_t e;
    int guard;
    for (int i = 0; i < 120; i++) begin
      tick(e);
      tests++;
      if ({hs2, vs2, de2} !== {e.hs2, e.vs2, e.de}) begin
        fails++;
        $display("FAIL polarity k=%0d: hs=%b vs=%b de=%b required %b %b %b",
                 k, hs2, vs2, de2, e.hs2, e.vs2, e.de);
      end
    end
    guard = 0;
    while ((k % 14) != 3 && guard < 20) begin
      tick(e);
      guard++;
    end
    rst_n = 1'b0;
    tick(e);
    tests++;
    if ({de2, hs2, vs2, fs2, px2, de0, hs0, vs0, px0, addr0} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 24'h0, 19'h0}) begin
      fails++;
      $display("FAIL mid_reset: de2=%b hs2=%b vs2=%b px2=%h de0=%b hs0=%b vs0=%b addr0=%h required reset values",
               de2, hs2, vs2, px2, de0, hs0, vs0, addr0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(e);
      tests++;
      if ({de2, hs2, vs2, fs2} !== {e.de, e.hs2, e.vs2, e.fs}) begin
        fails++;
        $display("FAIL post_reset k=%0d: de=%b hs=%b vs=%b fs=%b required %b %b %b %b",
                 k, de2, hs2, vs2, fs2, e.de, e.hs2, e.vs2, e.fs);
      end
    end
  endtask

`ifdef HDMI_TIMING_GEN_PATTERN_EN
  task automatic test_pattern();
    exp_t e;
    for (int p = 1; p >= 0; p--) begin
      pattern = p[0];
      for (int i = 0; i < 116; i++) begin
        tick(e);
        tests++;
        if ({de0, px0} !== {e.de, e.px0}) begin
          fails++;
          $display("FAIL pattern%0d k=%0d: px=%h required %h", p, k, px0, e.px0);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_data();
    test_scale();
    test_en_drop();
    test_polarity();
`ifdef HDMI_TIMING_GEN_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hdmi_timing_gen.md
Name: hdmi_timing_gen

Overview:
Parametrised video timing generator and pixel-fetch sequencer for the ADV7513 HDMI path. It generates DE/HSYNC/VSYNC for any resolution and sync polarity, and drives the address of an external pixel ROM. It compensates a configurable ROM read latency and supports integer pixel replication, so a small image can fill the screen. It sits between the pixel-clock source and the HDMI output pins, and is enabled once I2C configuration completes.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HSYNC asserted level (0 = active low)
VS_POL, 0, VSYNC asserted level
CTR_WIDTH, 12, width of the h/v counters; must hold H_TOTAL-1 and V_TOTAL-1
ADDR_WIDTH, 19, width of PX_ADDR
PIPE_DEPTH, 2, cycles from PX_ADDR to a valid PX_IN (valid range 1..8)
SCALE_SHIFT, 0, pixel/line replication factor 2^SCALE_SHIFT

Ports:
CLK_PX  in  1  pixel clock; the only clock
RST_n  in  1  synchronous, active-low reset
EN  in  1  timing enable (typically I2C config done)
PX_IN  in  24  pixel data from ROM, {R,G,B}
PX_ADDR  out  ADDR_WIDTH  pixel ROM address, registered
DE  out  1  data enable
HSYNC  out  1  horizontal sync
VSYNC  out  1  vertical sync
HDMI_PX  out  24  output pixel, registered
FRAME_START  out  1  one-cycle pulse coincident with first DE of each frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h counts 0..H_TOTAL-1. v increments when h wraps and itself wraps at V_TOTAL-1.
- Region order: active, FP, SYNC, BP.
- Stage 0 (counter state): active = h<H_ACTIVE && v<V_ACTIVE.
- Stage 0 sync: hs_asrt for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs_asrt on the same rule applied to v (whole lines).
- Address: an internal addr is 0 at (h,v)=(0,0).
  - During active pixels, addr increments after each pixel whose h[SCALE_SHIFT-1:0] is all ones.
  - At the end of each active line, addr reloads line_base unless v[SCALE_SHIFT-1:0] is all ones; in that case line_base takes addr.
  - SCALE_SHIFT=0 gives a plain linear count. No multipliers.
- PX_ADDR is registered from addr, so it is valid 1 cycle after its counter state. During blanking it holds its last value.
- PX_IN for that address arrives PIPE_DEPTH cycles later. HDMI_PX registers it (or 0 when delayed active = 0).
- active, hs_asrt, vs_asrt and the frame-start flag pass through a shift pipeline of L = PIPE_DEPTH+2 stages, so all outputs align with HDMI_PX.
- Output levels: HSYNC = hs_asrt ? HS_POL : ~HS_POL; VSYNC likewise with VS_POL.
- Reset (RST_n=0 at edge): h=v=addr=line_base=0; PX_ADDR=0, HDMI_PX=0, DE=0, FRAME_START=0, HSYNC=~HS_POL, VSYNC=~VS_POL. All pipeline stages are loaded with these inactive values.
- EN=0 at an edge:
  - Counters and addr are forced to 0 and the whole pipeline is flushed to inactive.
  - Outputs are inactive from that edge onward. Reset has priority over EN.
- EN rising: the counter is at (0,0) in the first cycle with EN high. DE and FRAME_START assert L cycles later. A mid-frame EN drop restarts at a clean frame.

Optional Feature:
Macro HDMI_TIMING_GEN_PATTERN_EN.
- Defined:
  - Adds input port PATTERN (1 bit), sampled at stage 0 and delayed with the pipeline.
  - When set, HDMI_PX during DE is replaced by 8 vertical colour bars chosen from the delayed h.
  - Bar i covers [i*H_ACTIVE/8, (i+1)*H_ACTIVE/8), using elaboration-time constants.
  - Bar colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - PX_ADDR sequencing is unchanged.
- Undefined: no PATTERN port; HDMI_PX always comes from PX_IN.

Test Plan:
Bench parameters unless noted: H 8/2/3/1 (H_TOTAL 14), V 4/1/2/1 (V_TOTAL 8), PIPE_DEPTH=2 (L=4). ROM model returns PX_IN = {5'b0, PX_ADDR} delayed 2 cycles.
1. Timing: reset, then EN=1 → DE first high 4 cycles after EN.
   - DE high 8 cycles per line for lines 0..3.
   - HSYNC low for 3 cycles starting 10+4 cycles after each line start.
   - VSYNC low for lines 5..6.
   - FRAME_START pulses every 112 cycles.
2. Latency/data: HDMI_PX during DE reads 0..7 on line 0, 8..15 on line 1, ..., 31 at the last active pixel. HDMI_PX=0 in blanking.
3. SCALE_SHIFT=1: HDMI_PX per line = 0,0,1,1,2,2,3,3 for lines 0-1 and 4,4,5,5,6,6,7,7 for lines 2-3. The next frame restarts at 0.
4. EN=0 at h=5,v=2 for 3 cycles → DE=0, HSYNC=VSYNC=1 and HDMI_PX=0 from the next edge. After EN returns, the first DE comes 4 cycles later with HDMI_PX=0 and FRAME_START=1.
5. HS_POL=1, VS_POL=1 → HSYNC/VSYNC idle low and high only in sync regions. RST_n=0 mid-line → all outputs take reset values at that edge.
6. Macro defined, PATTERN=1 → the 8 active pixels per line output FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. PATTERN=0 → matches scenario 2.
